// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: parity modes, receiver FSM
// states, parameter legality and the 3-sample majority helper.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_mode_e;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4
    } rx_state_e;

    function automatic bit rx_params_legal(input int data_bits, input int parity_mode,
                                           input int stop_bits, input int oversample);
        return (data_bits >= 5) && (data_bits <= 9) &&
               (parity_mode >= 0) && (parity_mode <= 2) &&
               ((stop_bits == 1) || (stop_bits == 2)) &&
               (oversample >= 8) && ((oversample % 2) == 0);
    endfunction

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input; both flops
// come out of reset at RESET_VAL so an idle line does not look like an edge.
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Metastability filter: two back-to-back flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: synchronised input, 3-sample majority vote,
// false-start rejection, parity/framing/break flags and valid/ready output.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1,
    parameter int OVERSAMPLE  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 oversample_tick,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid,
    input  logic                 ready,
    output logic                 parity_error,
    output logic                 frame_error,
    output logic                 break_det,
    output logic                 overrun
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] TCNT_ONE  = TW'(1);
    localparam logic [TW-1:0] TCNT_MAX  = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] VOTE_A    = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] VOTE_B    = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0] VOTE_C    = TW'(OVERSAMPLE / 2 + 1);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
    localparam parity_mode_e  PMODE     = parity_mode_e'(2'(PARITY_MODE));

    if (!rx_params_legal(DATA_BITS, PARITY_MODE, STOP_BITS, OVERSAMPLE)) begin : g_bad_params
        $error("uart_rx_param: illegal parameter combination");
    end

    logic rxd_s;

    uart_sync2 #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (rxd),
        .q_o   (rxd_s)
    );

    rx_state_e              state_q;
    logic [TW-1:0]          tcnt_q;
    logic [3:0]             bcnt_q;
    logic [1:0]             smp_q;
    logic [DATA_BITS-1:0]   shift_q;
    logic                   par_q;
    logic                   stop_err_q;
    logic                   stop_all0_q;
    logic [DATA_BITS-1:0]   data_out_q;
    logic                   valid_q;
    logic                   parity_error_q;
    logic                   frame_error_q;
    logic                   break_det_q;
    logic                   overrun_q;

    logic                   at_samp_s;
    logic                   at_vote_s;
    logic                   at_wrap_s;
    logic                   vote_s;
    logic                   accept_s;
    logic                   frame_err_d;
    logic                   stop_all0_d;
    logic                   par_err_d;
    logic                   brk_d;

    // Tick-position decodes and the majority of the two stored samples plus the live one.
    always_comb begin
        at_samp_s   = oversample_tick && ((tcnt_q == VOTE_A) || (tcnt_q == VOTE_B));
        at_vote_s   = oversample_tick && (tcnt_q == VOTE_C);
        at_wrap_s   = oversample_tick && (tcnt_q == TCNT_MAX);
        vote_s      = majority3(smp_q[1], smp_q[0], rxd_s);
        accept_s    = !valid_q || ready;
        frame_err_d = stop_err_q | ~vote_s;
        stop_all0_d = stop_all0_q & ~vote_s;
    end

    // Frame-level flags evaluated at the final stop-bit vote.
    always_comb begin
        par_err_d = 1'b0;
        case (PMODE)
            PAR_EVEN: par_err_d = ^{shift_q, par_q};
            PAR_ODD:  par_err_d = ~^{shift_q, par_q};
            default:  par_err_d = 1'b0;
        endcase
        if ((shift_q == '0) && ((PMODE == PAR_NONE) || !par_q) && stop_all0_d) begin
            brk_d = 1'b1;
        end else begin
            brk_d = 1'b0;
        end
    end

    // Receiver FSM, bit timing and registered output/handshake state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= RX_IDLE;
            tcnt_q         <= '0;
            bcnt_q         <= 4'd0;
            smp_q          <= 2'b11;
            shift_q        <= '0;
            par_q          <= 1'b0;
            stop_err_q     <= 1'b0;
            stop_all0_q    <= 1'b1;
            data_out_q     <= '0;
            valid_q        <= 1'b0;
            parity_error_q <= 1'b0;
            frame_error_q  <= 1'b0;
            break_det_q    <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            if (valid_q && ready) begin
                valid_q <= 1'b0;
            end
            if (at_samp_s) begin
                smp_q <= {smp_q[0], rxd_s};
            end
            if (oversample_tick && (state_q != RX_IDLE)) begin
                tcnt_q <= at_wrap_s ? '0 : tcnt_q + TCNT_ONE;
            end

            case (state_q)
                RX_IDLE: begin
                    if (oversample_tick && !rxd_s) begin
                        tcnt_q  <= TCNT_ONE;
                        state_q <= RX_START;
                    end
                end
                RX_START: begin
                    if (at_vote_s && vote_s) begin
                        state_q <= RX_IDLE;
                        tcnt_q  <= '0;
                    end else if (at_wrap_s) begin
                        state_q     <= RX_DATA;
                        bcnt_q      <= 4'd0;
                        par_q       <= 1'b0;
                        stop_err_q  <= 1'b0;
                        stop_all0_q <= 1'b1;
                    end
                end
                RX_DATA: begin
                    if (at_vote_s) begin
                        shift_q <= {vote_s, shift_q[DATA_BITS-1:1]};
                    end
                    if (at_wrap_s) begin
                        if (bcnt_q == DATA_LAST) begin
                            bcnt_q  <= 4'd0;
                            state_q <= (PMODE == PAR_NONE) ? RX_STOP : RX_PARITY;
                        end else begin
                            bcnt_q <= bcnt_q + 4'd1;
                        end
                    end
                end
                RX_PARITY: begin
                    if (at_vote_s) begin
                        par_q <= vote_s;
                    end else if (at_wrap_s) begin
                        state_q <= RX_STOP;
                    end
                end
                RX_STOP: begin
                    if (at_vote_s) begin
                        stop_err_q  <= frame_err_d;
                        stop_all0_q <= stop_all0_d;
                        // Leave before the bit ends so a back-to-back start bit is seen.
                        if (bcnt_q == STOP_LAST) begin
                            state_q <= RX_IDLE;
                            tcnt_q  <= '0;
                            bcnt_q  <= 4'd0;
                            if (accept_s) begin
                                data_out_q     <= shift_q;
                                parity_error_q <= par_err_d;
                                frame_error_q  <= frame_err_d;
                                break_det_q    <= brk_d;
                                valid_q        <= 1'b1;
                            end else begin
                                overrun_q <= 1'b1;
                            end
                        end
                    end else if (at_wrap_s) begin
                        bcnt_q <= bcnt_q + 4'd1;
                    end
                end
                default: begin
                    state_q <= RX_IDLE;
                    tcnt_q  <= '0;
                end
            endcase
        end
    end

    assign data_out     = data_out_q;
    assign valid        = valid_q;
    assign parity_error = parity_error_q;
    assign frame_error  = frame_error_q;
    assign break_det    = break_det_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: 8N1, 7E1 and 8O2 instances driven from
// one stimulus sequence, outputs checked against a queue of expected frames.
module tb_uart_rx_param;

    typedef struct {
        int         id;
        logic [8:0] data;
        logic       pe;
        logic       fe;
        logic       bd;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   tick_div = 0;
    int   ovr_cnt[3];

    logic       clk = 1'b0;
    logic       tick = 1'b0;
    logic       rst_all = 1'b1;
    logic       rst2 = 1'b0;
    logic [2:0] rxd_l = 3'b111;
    logic [2:0] ready_l = 3'b111;
    logic [2:0] clr_pend = 3'b000;

    logic [7:0] d0;
    logic [6:0] d1;
    logic [7:0] d2;
    logic [2:0] valid_w, pe_w, fe_w, bd_w, ovr_w;

    always #5 clk = ~clk;

    uart_rx_param #(.DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1), .OVERSAMPLE(16)) u_8n1 (
        .clk(clk), .reset(rst_all), .oversample_tick(tick), .rxd(rxd_l[0]),
        .data_out(d0), .valid(valid_w[0]), .ready(ready_l[0]),
        .parity_error(pe_w[0]), .frame_error(fe_w[0]), .break_det(bd_w[0]), .overrun(ovr_w[0]));

    uart_rx_param #(.DATA_BITS(7), .PARITY_MODE(1), .STOP_BITS(1), .OVERSAMPLE(16)) u_7e1 (
        .clk(clk), .reset(rst_all), .oversample_tick(tick), .rxd(rxd_l[1]),
        .data_out(d1), .valid(valid_w[1]), .ready(ready_l[1]),
        .parity_error(pe_w[1]), .frame_error(fe_w[1]), .break_det(bd_w[1]), .overrun(ovr_w[1]));

    uart_rx_param #(.DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(2), .OVERSAMPLE(16)) u_8o2 (
        .clk(clk), .reset(rst_all | rst2), .oversample_tick(tick), .rxd(rxd_l[2]),
        .data_out(d2), .valid(valid_w[2]), .ready(ready_l[2]),
        .parity_error(pe_w[2]), .frame_error(fe_w[2]), .break_det(bd_w[2]), .overrun(ovr_w[2]));

    // One-clk tick every fourth clock.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            tick = (tick_div == 3);
            tick_div = (tick_div + 1) % 4;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            do @(posedge clk); while (tick !== 1'b1);
        end
        #1;
    endtask

    task automatic send_frame(input int id, input int nbits, input logic [8:0] data,
                              input int pmode, input bit force_par, input logic par_val,
                              input int nstop, input logic [1:0] stops,
                              input int glitch_bit, input bit expect_out);
        logic [8:0] dm;
        logic       par;
        logic       any0;
        logic       all0;
        exp_t       e;
        dm = data & ((9'h001 << nbits) - 9'h001);
        par = (pmode == 2) ? ~^dm : ^dm;
        if (force_par) par = par_val;
        any0 = 1'b0;
        all0 = 1'b1;
        for (int s = 0; s < nstop; s++) begin
            any0 = any0 | ~stops[s];
            all0 = all0 & ~stops[s];
        end
        e.id   = id;
        e.data = dm;
        e.pe   = (pmode != 0) && ((^dm ^ par) != (pmode == 2));
        e.fe   = any0;
        e.bd   = (dm == 9'h000) && ((pmode == 0) || !par) && all0;
        if (expect_out) exp_q.push_back(e);
        rxd_l[id] = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < nbits; i++) begin
            if (i == glitch_bit) begin
                rxd_l[id] = 1'b1; wait_ticks(8);
                rxd_l[id] = 1'b0; wait_ticks(1);
                rxd_l[id] = 1'b1; wait_ticks(7);
            end else begin
                rxd_l[id] = dm[i];
                wait_ticks(16);
            end
        end
        if (pmode != 0) begin
            rxd_l[id] = par;
            wait_ticks(16);
        end
        for (int s = 0; s < nstop; s++) begin
            rxd_l[id] = stops[s];
            wait_ticks(16);
        end
        rxd_l[id] = 1'b1;
        wait_ticks(32);
    endtask

    // Scoreboard side: pop on every handshake, then require valid to drop.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            logic [8:0] obs_d;
            exp_t       e;
            if (ovr_w[k]) ovr_cnt[k]++;
            case (k)
                0:       obs_d = {1'b0, d0};
                1:       obs_d = {2'b00, d1};
                default: obs_d = {1'b0, d2};
            endcase
            if (clr_pend[k]) begin
                check("valid_clear", {31'd0, valid_w[k]}, 32'd0);
                clr_pend[k] = 1'b0;
            end else if (valid_w[k] && ready_l[k]) begin
                n_tests++;
                assert (exp_q.size() > 0) else begin
                    n_fail++;
                    $error("FAIL unexpected_frame: dut %0d data %0h, none expected", k, obs_d);
                end
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("frame_dut", k, e.id);
                    check("data_out", {23'd0, obs_d}, {23'd0, e.data});
                    check("parity_error", {31'd0, pe_w[k]}, {31'd0, e.pe});
                    check("frame_error", {31'd0, fe_w[k]}, {31'd0, e.fe});
                    check("break_det", {31'd0, bd_w[k]}, {31'd0, e.bd});
                end
                clr_pend[k] = 1'b1;
            end
        end
    end

    initial begin
        exp_t e;
        ovr_cnt[0] = 0; ovr_cnt[1] = 0; ovr_cnt[2] = 0;
        repeat (3) @(posedge clk);
        #1 rst_all = 1'b0;
        wait_ticks(4);
        check("rst_valid", {29'd0, valid_w}, 32'd0);
        check("rst_data", {9'd0, d0, d1, d2}, 32'd0);
        check("rst_flags", {20'd0, pe_w, fe_w, bd_w, ovr_w}, 32'd0);

        // 8N1 0xA5, clean frame
        send_frame(0, 8, 9'h0A5, 0, 1'b0, 1'b0, 1, 2'b11, -1, 1'b1);
        // 7E1 0x35 with the parity bit forced wrong
        send_frame(1, 7, 9'h035, 1, 1'b1, 1'b1, 1, 2'b11, -1, 1'b1);
        // 4-tick low pulse is a false start
        rxd_l[0] = 1'b0; wait_ticks(4);
        rxd_l[0] = 1'b1; wait_ticks(32);
        check("false_start_valid", {31'd0, valid_w[0]}, 32'd0);
        send_frame(0, 8, 9'h03C, 0, 1'b0, 1'b0, 1, 2'b11, -1, 1'b1);
        // Single-sample glitch on data bit 3 is outvoted
        send_frame(0, 8, 9'h0FF, 0, 1'b0, 1'b0, 1, 2'b11, 3, 1'b1);

        // 12 bit times low: a break frame, then a restart that sees the line
        // go high from its data bit 1 onwards, giving 0xFE.
        e.id = 0; e.data = 9'h000; e.pe = 1'b0; e.fe = 1'b1; e.bd = 1'b1;
        exp_q.push_back(e);
        e.id = 0; e.data = 9'h0FE; e.pe = 1'b0; e.fe = 1'b0; e.bd = 1'b0;
        exp_q.push_back(e);
        rxd_l[0] = 1'b0; wait_ticks(192);
        rxd_l[0] = 1'b1; wait_ticks(160);

        // Overrun: hold ready low across two frames
        ready_l[0] = 1'b0;
        send_frame(0, 8, 9'h011, 0, 1'b0, 1'b0, 1, 2'b11, -1, 1'b1);
        send_frame(0, 8, 9'h022, 0, 1'b0, 1'b0, 1, 2'b11, -1, 1'b0);
        check("ovr_valid_held", {31'd0, valid_w[0]}, 32'd1);
        check("ovr_data_held", {24'd0, d0}, 32'h11);
        check("ovr_pulses", ovr_cnt[0], 32'd1);
        ready_l[0] = 1'b1;
        wait_ticks(2);
        check("ovr_valid_cleared", {31'd0, valid_w[0]}, 32'd0);

        // 8O2: hold a frame, then reset mid data bit 4 of the next one
        ready_l[2] = 1'b0;
        send_frame(2, 8, 9'h05A, 2, 1'b0, 1'b0, 2, 2'b11, -1, 1'b0);
        check("o2_valid_held", {31'd0, valid_w[2]}, 32'd1);
        check("o2_data_held", {24'd0, d2}, 32'h5A);
        check("o2_parity_ok", {31'd0, pe_w[2]}, 32'd0);
        rxd_l[2] = 1'b0;
        wait_ticks(16 + 4 * 16 + 8);
        rst2 = 1'b1;
        #2;
        check("mid_reset_data", {24'd0, d2}, 32'd0);
        check("mid_reset_ctrl", {27'd0, valid_w[2], pe_w[2], fe_w[2], bd_w[2], ovr_w[2]}, 32'd0);
        rxd_l[2] = 1'b1;
        wait_ticks(4);
        rst2 = 1'b0;
        wait_ticks(32);
        check("post_reset_valid", {31'd0, valid_w[2]}, 32'd0);
        ready_l[2] = 1'b1;
        send_frame(2, 8, 9'h080, 2, 1'b0, 1'b0, 2, 2'b01, -1, 1'b1);
        wait_ticks(16);

        check("frames_pending", exp_q.size(), 32'd0);
        check("ovr_other", ovr_cnt[1] + ovr_cnt[2], 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_param.md
# uart_rx_param

Parametrised UART receiver: the next-generation serial receive path of the UART. It runs on one system clock and uses an external oversample-tick enable. It supports configurable data width, parity mode and stop-bit count. It also adds input synchronisation, 3-sample majority voting, false-start rejection, framing and break detection, and a valid/ready output handshake with overrun reporting. It sits between the pad-side `rxd` line and the receive buffer or host interface.

## Interface
- `DATA_BITS`, 8: data bits per frame, legal 5..9.
- `PARITY_MODE`, 0: 0 none, 1 even, 2 odd.
- `STOP_BITS`, 1: legal 1 or 2.
- `OVERSAMPLE`, 16: ticks per bit, even, ≥8.
- `clk` in 1: system clock; all logic on rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `oversample_tick` in 1: one-`clk` enable pulse, OVERSAMPLE per bit time.
- `rxd` in 1: asynchronous serial input, idle high.
- `data_out` out DATA_BITS: received word, LSB first on the line.
- `valid` out 1: `data_out` and error flags hold a frame.
- `ready` in 1: consumer accepts the frame when `valid && ready`.
- `parity_error` out 1: parity mismatch for the held frame (0 if PARITY_MODE=0).
- `frame_error` out 1: any stop bit sampled 0 in the held frame.
- `break_det` out 1: held frame has all data bits 0, parity 0 if present, and stop 0.
- `overrun` out 1: one-`clk` pulse when a completed frame is dropped.

## Operation
- `rxd` passes through a 2-flop synchroniser; both flops reset to 1. All decisions use the synchronised value.
- Tick counter `tcnt` runs 0..OVERSAMPLE-1 and advances only on `oversample_tick`.
- Votes are taken at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1. The bit value is the majority of the three.
- FSM states:
  - IDLE: on a tick with synced `rxd`=0, `tcnt`←1 and go to START.
  - START: at the vote point, a majority of 1 is a false start and returns to IDLE with no output. Otherwise the FSM waits for `tcnt` wrap and goes to DATA.
  - DATA: shift the voted bit in LSB-first. After DATA_BITS bits, go to PARITY if PARITY_MODE≠0, else to STOP.
  - PARITY: capture the voted parity bit. Even mode expects XOR(data, parity)=0; odd mode expects 1.
  - STOP: vote each stop bit. After the last stop bit's final vote sample, the frame completes and the FSM goes to IDLE immediately, without waiting for the bit end, so a back-to-back start bit is caught.
- `frame_error` is the OR of all stop bits voted 0.
- `break_det` implies `frame_error`.
- On frame completion:
  - If `valid`=0, or `valid && ready` in the same cycle, load `data_out` and the three flags and set `valid`=1.
  - Otherwise keep the old frame, discard the new one, and pulse `overrun`.
- `valid && ready` with no new frame clears `valid`. `data_out` and the flags hold their last values.

## Timing
- Reset: `data_out`=0, `valid`=0, `parity_error`=0, `frame_error`=0, `break_det`=0, `overrun`=0; FSM in IDLE; `tcnt`=0; shift register 0.
- `valid` rises on the `clk` edge after the tick carrying the last stop bit's third vote sample. It stays high until the handshake.
- Input synchroniser latency is 2 `clk`. Latency stays bounded as long as the tick period is 3 `clk` or more.
- A start edge is recognised only on a tick. Jitter is up to 1 tick plus 2 `clk`.
- Reset asserted mid-frame aborts immediately. No partial frame and no flags are produced. Reception resumes from IDLE after a high-to-low edge.
- `ready` is ignored while `valid`=0.
- With `OVERSAMPLE`=16, the vote ticks are 7, 8 and 9.

## Structure
- Shared package `uart_pkg` holds:
  - the parity-mode enum (`PAR_NONE`, `PAR_EVEN`, `PAR_ODD`);
  - the FSM state enum (`RX_IDLE`, `RX_START`, `RX_DATA`, `RX_PARITY`, `RX_STOP`);
  - parameter-legality checks.
- One sub-module, `uart_sync2`: the 2-flop synchroniser with parameterised reset value.
- The vote logic is inline: a 2-bit sample shift plus majority.

## Test plan
- 8N1, OVERSAMPLE=16, send 0xA5 with `ready`=1: `data_out`=0xA5, one `valid` cycle, all flags 0.
- 7E1, send 0x35 with parity bit forced to 1: `data_out`=0x35, `parity_error`=1, `frame_error`=0.
- `rxd` low pulse of 4 ticks in IDLE: false start, no `valid`. Then 0x3C 8N1: received correctly.
- 8N1, bit 3 of 0xFF pulled low only on vote tick 8: majority yields 0xFF. Line held low 12 bit times: `data_out`=0x00, `frame_error`=1, `break_det`=1.
- `ready`=0, send 0x11 then 0x22: `data_out`=0x11, `valid`=1, one `overrun` pulse. Then `ready`=1: `valid` clears after 1 `clk`.
- 8O2, assert `reset` during data bit 4: all outputs 0. Then send 0x80 with second stop bit 0: `data_out`=0x80, `frame_error`=1, `parity_error`=0.
